// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage registers: payload widths,
// NOP encoding and the stage-buffer state encoding.
package cpu_pipe_pkg;

    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 110;
    localparam int MEMWB_W = 71;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // The state encoding doubles as the entry count.
    function automatic logic [1:0] occ_of(input state_e st);
        case (st)
            ST_EMPTY: occ_of = 2'd0;
            ST_ONE:   occ_of = 2'd1;
            ST_FULL:  occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between pipeline stages.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with synchronous reset and clear to RST_VALUE.
module pipe_data_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RST_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        if (clr) begin
            data_d = RST_VALUE;
        end else if (ld) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer and synchronous flush that leaves a NOP bubble.
module pipe_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W    = IFID_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter bit                SKID      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_buf_if.slave         in_if,
    pipe_stage_buf_if.master        out_if,
    output logic [1:0]              occupancy
);

    state_e            state_d, state_q;
    logic              out_valid_d, out_valid_q;
    logic              in_ready_d, in_ready_q;
    logic              in_ready_s;
    logic              in_xfer_s, out_xfer_s;
    logic              main_ld_s, main_clr_s, skid_ld_s, skid_clr_s;
    logic [DATA_W-1:0] main_din_s, main_q_s, skid_q_s;

    // Flush gates in_ready so upstream never counts a squashed payload as sent.
    assign in_ready_s = (SKID ? in_ready_q : (!out_valid_q || out_if.ready)) && !flush;
    assign in_xfer_s  = in_if.valid && in_ready_s;
    assign out_xfer_s = out_valid_q && out_if.ready;

    always_comb begin
        state_d    = state_q;
        main_ld_s  = 1'b0;
        main_clr_s = 1'b0;
        skid_ld_s  = 1'b0;
        skid_clr_s = 1'b0;
        main_din_s = in_if.data;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_ld_s = 1'b1;
                        state_d   = ST_ONE;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_ld_s  = 1'b1;
                        state_d    = ST_ONE;
                    end else if (in_xfer_s) begin
                        skid_ld_s  = 1'b1;
                        state_d    = ST_FULL;
                    end else if (out_xfer_s) begin
                        main_clr_s = 1'b1;
                        state_d    = ST_EMPTY;
                    end else begin
                        state_d    = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        main_ld_s  = 1'b1;
                        main_din_s = skid_q_s;
                        skid_clr_s = 1'b1;
                        state_d    = ST_ONE;
                    end else begin
                        state_d    = ST_FULL;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    pipe_data_reg #(
        .DATA_W    (DATA_W),
        .RST_VALUE (NOP_VALUE)
    ) u_main_reg (
        .clk (clk),
        .rst (rst),
        .clr (main_clr_s),
        .ld  (main_ld_s),
        .d   (main_din_s),
        .q   (main_q_s)
    );

    generate
        if (SKID) begin : g_skid
            pipe_data_reg #(
                .DATA_W    (DATA_W),
                .RST_VALUE (NOP_VALUE)
            ) u_skid_reg (
                .clk (clk),
                .rst (rst),
                .clr (skid_clr_s),
                .ld  (skid_ld_s),
                .d   (in_if.data),
                .q   (skid_q_s)
            );
        end else begin : g_no_skid
            assign skid_q_s = NOP_VALUE;
        end
    endgenerate

    assign in_if.ready  = in_ready_s;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = main_q_s;
    assign occupancy    = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and randomized checks of pipe_stage_buf in SKID=1 and SKID=0 builds.
module tb_pipe_stage_buf;

    localparam logic [63:0] NOP_A = 64'h0;
    localparam logic [63:0] NOP_B = 64'hDEAD_BEEF_0000_0013;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_a, flush_b;
    logic [1:0] occ_a, occ_b;
    int         vec_cnt = 0;
    int         err_cnt = 0;

    pipe_stage_buf_if #(.DATA_W(64)) a_in ();
    pipe_stage_buf_if #(.DATA_W(64)) a_out ();
    pipe_stage_buf_if #(.DATA_W(64)) b_in ();
    pipe_stage_buf_if #(.DATA_W(64)) b_out ();

    pipe_stage_buf #(.DATA_W(64), .NOP_VALUE(NOP_A), .SKID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a),
        .in_if(a_in), .out_if(a_out), .occupancy(occ_a)
    );

    pipe_stage_buf #(.DATA_W(64), .NOP_VALUE(NOP_B), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .in_if(b_in), .out_if(b_out), .occupancy(occ_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        a_in.valid = 1'b1; a_in.data = 64'hAAAA; a_out.ready = 1'b1;
        b_in.valid = 1'b1; b_in.data = 64'hAAAA; b_out.ready = 1'b1;
        tick(); tick();
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL rst_a_valid got %b exp 0", a_out.valid); end
        vec_cnt++; if (a_out.data !== NOP_A) begin err_cnt++; $display("FAIL rst_a_data got %h exp %h", a_out.data, NOP_A); end
        vec_cnt++; if (occ_a !== 2'd0) begin err_cnt++; $display("FAIL rst_a_occ got %0d exp 0", occ_a); end
        vec_cnt++; if (b_out.valid !== 1'b0) begin err_cnt++; $display("FAIL rst_b_valid got %b exp 0", b_out.valid); end
        vec_cnt++; if (b_out.data !== NOP_B) begin err_cnt++; $display("FAIL rst_b_data got %h exp %h", b_out.data, NOP_B); end
        vec_cnt++; if (occ_b !== 2'd0) begin err_cnt++; $display("FAIL rst_b_occ got %0d exp 0", occ_b); end
        rst = 1'b0; a_in.valid = 1'b0; b_in.valid = 1'b0;
        tick();
        vec_cnt++; if (a_in.ready !== 1'b1) begin err_cnt++; $display("FAIL rst_a_in_ready got %b exp 1", a_in.ready); end
        vec_cnt++; if (b_in.ready !== 1'b1) begin err_cnt++; $display("FAIL rst_b_in_ready got %b exp 1", b_in.ready); end
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL rst_a_valid_post got %b exp 0", a_out.valid); end
    endtask

    task automatic test_streaming();
        logic [63:0] exp_d;
        a_out.ready = 1'b1;
        a_in.valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_d = 64'(i);
            a_in.data = exp_d;
            tick();
            vec_cnt++; if (a_out.data !== exp_d) begin err_cnt++; $display("FAIL stream_data got %h exp %h", a_out.data, exp_d); end
            vec_cnt++; if (a_out.valid !== 1'b1) begin err_cnt++; $display("FAIL stream_valid got %b exp 1", a_out.valid); end
            vec_cnt++; if (occ_a !== 2'd1) begin err_cnt++; $display("FAIL stream_occ got %0d exp 1", occ_a); end
        end
        a_in.valid = 1'b0;
        tick();
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL stream_drain_valid got %b exp 0", a_out.valid); end
        vec_cnt++; if (a_out.data !== NOP_A) begin err_cnt++; $display("FAIL stream_drain_data got %h exp %h", a_out.data, NOP_A); end
    endtask

    task automatic fill_5_6();
        a_out.ready = 1'b0;
        a_in.valid  = 1'b1;
        a_in.data   = 64'd5;
        tick();
        vec_cnt++; if (occ_a !== 2'd1) begin err_cnt++; $display("FAIL fill_occ1 got %0d exp 1", occ_a); end
        a_in.data = 64'd6;
        tick();
        vec_cnt++; if (occ_a !== 2'd2) begin err_cnt++; $display("FAIL fill_occ2 got %0d exp 2", occ_a); end
        vec_cnt++; if (a_in.ready !== 1'b0) begin err_cnt++; $display("FAIL fill_in_ready got %b exp 0", a_in.ready); end
        vec_cnt++; if (a_out.data !== 64'd5) begin err_cnt++; $display("FAIL fill_head got %h exp 5", a_out.data); end
    endtask

    task automatic test_stall();
        fill_5_6();
        a_in.valid = 1'b0;
        tick();
        vec_cnt++; if (a_out.data !== 64'd5 || a_out.valid !== 1'b1) begin err_cnt++; $display("FAIL stall_hold got %h/%b exp 5/1", a_out.data, a_out.valid); end
        a_out.ready = 1'b1;
        #1;
        vec_cnt++; if (a_out.data !== 64'd5) begin err_cnt++; $display("FAIL stall_first got %h exp 5", a_out.data); end
        tick();
        vec_cnt++; if (a_out.data !== 64'd6 || a_out.valid !== 1'b1) begin err_cnt++; $display("FAIL stall_second got %h/%b exp 6/1", a_out.data, a_out.valid); end
        vec_cnt++; if (occ_a !== 2'd1) begin err_cnt++; $display("FAIL stall_occ got %0d exp 1", occ_a); end
        vec_cnt++; if (a_in.ready !== 1'b1) begin err_cnt++; $display("FAIL stall_in_ready got %b exp 1", a_in.ready); end
        tick();
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL stall_empty got %b exp 0", a_out.valid); end
    endtask

    task automatic test_flush();
        fill_5_6();
        flush_a = 1'b1; a_in.valid = 1'b1; a_in.data = 64'd7;
        #1;
        vec_cnt++; if (a_in.ready !== 1'b0) begin err_cnt++; $display("FAIL flush_in_ready got %b exp 0", a_in.ready); end
        tick();
        flush_a = 1'b0; a_in.valid = 1'b0;
        #1;
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid got %b exp 0", a_out.valid); end
        vec_cnt++; if (a_out.data !== NOP_A) begin err_cnt++; $display("FAIL flush_data got %h exp %h", a_out.data, NOP_A); end
        vec_cnt++; if (occ_a !== 2'd0) begin err_cnt++; $display("FAIL flush_occ got %0d exp 0", occ_a); end
        vec_cnt++; if (a_in.ready !== 1'b1) begin err_cnt++; $display("FAIL flush_ready_after got %b exp 1", a_in.ready); end
        a_out.ready = 1'b1;
        tick();
        vec_cnt++; if (a_out.valid !== 1'b0) begin err_cnt++; $display("FAIL flush_no7 got %b/%h exp 0", a_out.valid, a_out.data); end
    endtask

    task automatic test_noskid();
        b_out.ready = 1'b0; b_in.valid = 1'b1; b_in.data = 64'h11;
        tick();
        vec_cnt++; if (occ_b !== 2'd1 || b_out.data !== 64'h11) begin err_cnt++; $display("FAIL nsk_load got %0d/%h exp 1/11", occ_b, b_out.data); end
        b_in.data = 64'h22;
        #1;
        vec_cnt++; if (b_in.ready !== 1'b0) begin err_cnt++; $display("FAIL nsk_stall_ready got %b exp 0", b_in.ready); end
        b_out.ready = 1'b1;
        #1;
        vec_cnt++; if (b_in.ready !== 1'b1) begin err_cnt++; $display("FAIL nsk_comb_ready got %b exp 1", b_in.ready); end
        tick();
        vec_cnt++; if (b_out.data !== 64'h22 || occ_b !== 2'd1) begin err_cnt++; $display("FAIL nsk_b2b got %h/%0d exp 22/1", b_out.data, occ_b); end
        b_in.data = 64'h33;
        tick();
        vec_cnt++; if (b_out.data !== 64'h33) begin err_cnt++; $display("FAIL nsk_b2b2 got %h exp 33", b_out.data); end
        b_in.valid = 1'b0;
        tick();
        vec_cnt++; if (b_out.valid !== 1'b0 || b_out.data !== NOP_B) begin err_cnt++; $display("FAIL nsk_empty got %b/%h exp 0/%h", b_out.valid, b_out.data, NOP_B); end
        b_in.valid = 1'b1; b_in.data = 64'h44; b_out.ready = 1'b0;
        tick();
        flush_b = 1'b1;
        #1;
        vec_cnt++; if (b_in.ready !== 1'b0) begin err_cnt++; $display("FAIL nsk_flush_ready got %b exp 0", b_in.ready); end
        tick();
        flush_b = 1'b0; b_in.valid = 1'b0;
        #1;
        vec_cnt++; if (b_out.valid !== 1'b0 || occ_b !== 2'd0) begin err_cnt++; $display("FAIL nsk_flush got %b/%0d exp 0/0", b_out.valid, occ_b); end
    endtask

    task automatic test_random();
        logic [63:0] qa[$];
        logic [63:0] qb[$];
        logic        rdy_a, rdy_b;
        logic [63:0] ed_a, ed_b;
        for (int n = 0; n < 10000; n++) begin
            tick();
            a_in.valid = ($urandom_range(0, 3) != 0); a_out.ready = ($urandom_range(0, 2) != 0);
            flush_a    = ($urandom_range(0, 31) == 0); a_in.data = {$urandom(), $urandom()};
            b_in.valid = ($urandom_range(0, 3) != 0); b_out.ready = ($urandom_range(0, 2) != 0);
            flush_b    = ($urandom_range(0, 31) == 0); b_in.data = {$urandom(), $urandom()};
            #1;
            rdy_a = (qa.size() < 2) && !flush_a;
            ed_a  = (qa.size() != 0) ? qa[0] : NOP_A;
            vec_cnt++; if (a_in.ready !== rdy_a) begin err_cnt++; $display("FAIL rnd_a_ready cyc %0d got %b exp %b", n, a_in.ready, rdy_a); end
            vec_cnt++; if (a_out.valid !== (qa.size() != 0) || a_out.data !== ed_a) begin err_cnt++; $display("FAIL rnd_a_out cyc %0d got %b/%h exp %0d/%h", n, a_out.valid, a_out.data, qa.size(), ed_a); end
            vec_cnt++; if (occ_a !== 2'(qa.size())) begin err_cnt++; $display("FAIL rnd_a_occ cyc %0d got %0d exp %0d", n, occ_a, qa.size()); end
            rdy_b = ((qb.size() == 0) || b_out.ready) && !flush_b;
            ed_b  = (qb.size() != 0) ? qb[0] : NOP_B;
            vec_cnt++; if (b_in.ready !== rdy_b) begin err_cnt++; $display("FAIL rnd_b_ready cyc %0d got %b exp %b", n, b_in.ready, rdy_b); end
            vec_cnt++; if (b_out.valid !== (qb.size() != 0) || b_out.data !== ed_b) begin err_cnt++; $display("FAIL rnd_b_out cyc %0d got %b/%h exp %0d/%h", n, b_out.valid, b_out.data, qb.size(), ed_b); end
            vec_cnt++; if (occ_b !== 2'(qb.size())) begin err_cnt++; $display("FAIL rnd_b_occ cyc %0d got %0d exp %0d", n, occ_b, qb.size()); end
            if (flush_a) begin
                qa.delete();
            end else begin
                if (qa.size() != 0 && a_out.ready) void'(qa.pop_front());
                if (a_in.valid && rdy_a) qa.push_back(a_in.data);
            end
            if (flush_b) begin
                qb.delete();
            end else begin
                if (qb.size() != 0 && b_out.ready) void'(qb.pop_front());
                if (b_in.valid && rdy_b) qb.push_back(b_in.data);
            end
        end
        a_in.valid = 1'b0; b_in.valid = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_noskid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
